// File: rtl/split_bus_arb_pkg.sv
// Shared types and helpers for the split-transaction bus arbiter.
package split_bus_arb_pkg;

  // Bus ownership state: free, normally owned, or owned by a returning split master.
  typedef enum logic [1:0] {
    StIdle,
    StOwned,
    StReturn
  } state_e;

  localparam int unsigned MAX_MASTERS = 4;

  // Width of a master index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/split_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr_i, wrapping.
module rr_priority_picker
  import split_bus_arb_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = 1
) (
  input  logic [NumReq-1:0] elig_i,
  input  logic [IdxW-1:0]   rr_ptr_i,
  output logic [IdxW-1:0]   winner_o,
  output logic              any_valid_o
);

  // Scan offsets from the far end down so the nearest eligible offset is the final write.
  always_comb begin
    int            idx_int;
    logic [IdxW-1:0] idx;
    idx_int     = 0;
    idx         = '0;
    winner_o    = '0;
    any_valid_o = |elig_i;
    for (int k = int'(NumReq) - 1; k >= 0; k--) begin
      idx_int = (int'(rr_ptr_i) + k) % int'(NumReq);
      idx     = idx_int[IdxW-1:0];
      if (elig_i[idx]) begin
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/split_bus_arbiter.sv
// Split-transaction bus arbiter for NUM_MASTERS initiators.
// Optional split timeout is enabled by defining SPLIT_TIMEOUT_EN.
module split_bus_arbiter
  import split_bus_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS   = 2,
  parameter int unsigned SPLIT_TIMEOUT = 255
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_MASTERS-1:0]             req,
  input  logic                               split_ack,
  input  logic                               arbiter_split_req,
  output logic [NUM_MASTERS-1:0]             grant,
  output logic                               split_grant,
  output logic                               split_pending,
  output logic [idx_width(NUM_MASTERS)-1:0]  split_owner,
  output logic                               split_err,
  output logic                               timeout_err
);

  localparam int unsigned IdxW = idx_width(NUM_MASTERS);
  localparam int unsigned CntW = $clog2(SPLIT_TIMEOUT + 1);

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        owner_q, owner_d;
  logic [IdxW-1:0]        rr_q, rr_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic                   split_grant_q, split_grant_d;
  logic                   split_pending_q, split_pending_d;
  logic [IdxW-1:0]        split_owner_q, split_owner_d;
  logic                   split_err_q, split_err_d;
  logic                   timeout_err_q, timeout_err_d;

  logic [NUM_MASTERS-1:0] split_mask, eligible;
  logic [IdxW-1:0]        winner;
  logic                   any_valid;
  logic                   timeout_hit;

  // The suspended master may not win the bus until its split resolves.
  always_comb begin
    split_mask = '0;
    if (split_pending_q) begin
      split_mask[split_owner_q] = 1'b1;
    end
    eligible = req & ~split_mask;
  end

  rr_priority_picker #(
    .NumReq (NUM_MASTERS),
    .IdxW   (IdxW)
  ) u_picker (
    .elig_i      (eligible),
    .rr_ptr_i    (rr_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

`ifdef SPLIT_TIMEOUT_EN
  logic [CntW-1:0] cnt_q, cnt_d;

  // Count cycles a split stays pending; held at zero otherwise.
  always_comb begin
    cnt_d = '0;
    if (split_pending_q) begin
      cnt_d = (cnt_q == CntW'(SPLIT_TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit = split_pending_q && (cnt_q == CntW'(SPLIT_TIMEOUT));
`else
  logic [CntW-1:0] unused_timeout_cfg;
  assign unused_timeout_cfg = CntW'(SPLIT_TIMEOUT);
  assign timeout_hit        = 1'b0;
`endif

  // Next-state: ownership, split bookkeeping and registered output pulses.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    rr_d            = rr_q;
    split_pending_d = split_pending_q;
    split_owner_d   = split_owner_q;
    split_grant_d   = 1'b0;
    split_err_d     = 1'b0;
    timeout_err_d   = 1'b0;
    grant_d         = '0;

    unique case (state_q)
      StIdle: begin
        if (split_ack) begin
          split_err_d = 1'b1;
        end
        // Returning the bus to the suspended master beats fresh requests.
        if (split_pending_q && arbiter_split_req) begin
          state_d         = StReturn;
          owner_d         = split_owner_q;
          split_pending_d = 1'b0;
          split_grant_d   = 1'b1;
        end else if (any_valid) begin
          state_d = StOwned;
          owner_d = winner;
          rr_d    = (winner == IdxW'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
        end
      end
      StOwned: begin
        // A split wins over a simultaneous release; a second split is an error.
        if (split_ack && !split_pending_q) begin
          state_d         = StIdle;
          split_pending_d = 1'b1;
          split_owner_d   = owner_q;
        end else begin
          if (split_ack) begin
            split_err_d = 1'b1;
          end
          if (!req[owner_q]) begin
            state_d = StIdle;
          end
        end
      end
      StReturn: begin
        if (split_ack) begin
          split_err_d = 1'b1;
        end
        if (!req[owner_q]) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (timeout_hit && !split_grant_d) begin
      split_pending_d = 1'b0;
      timeout_err_d   = 1'b1;
    end

    if (state_d != StIdle) begin
      grant_d[owner_d] = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      owner_q         <= '0;
      rr_q            <= '0;
      grant_q         <= '0;
      split_grant_q   <= 1'b0;
      split_pending_q <= 1'b0;
      split_owner_q   <= '0;
      split_err_q     <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      rr_q            <= rr_d;
      grant_q         <= grant_d;
      split_grant_q   <= split_grant_d;
      split_pending_q <= split_pending_d;
      split_owner_q   <= split_owner_d;
      split_err_q     <= split_err_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  assign grant         = grant_q;
  assign split_grant   = split_grant_q;
  assign split_pending = split_pending_q;
  assign split_owner   = split_owner_q;
  assign split_err     = split_err_q;
  assign timeout_err   = timeout_err_q;

endmodule
